// File: rtl/decode_stage_pkg.sv
// Shared decode definitions: RV32I opcodes, immediate formats and the
// decoded record held in each skid-buffer entry.
package decode_stage_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned OPC_W = 7;
    localparam int unsigned REG_W = 5;
    localparam int unsigned F3_W  = 3;
    localparam int unsigned F7_W  = 7;

    localparam logic [OPC_W-1:0] OP_LUI      = 7'b0110111;
    localparam logic [OPC_W-1:0] OP_AUIPC    = 7'b0010111;
    localparam logic [OPC_W-1:0] OP_JAL      = 7'b1101111;
    localparam logic [OPC_W-1:0] OP_JALR     = 7'b1100111;
    localparam logic [OPC_W-1:0] OP_BRANCH   = 7'b1100011;
    localparam logic [OPC_W-1:0] OP_LOAD     = 7'b0000011;
    localparam logic [OPC_W-1:0] OP_STORE    = 7'b0100011;
    localparam logic [OPC_W-1:0] OP_IMM      = 7'b0010011;
    localparam logic [OPC_W-1:0] OP_OP       = 7'b0110011;
    localparam logic [OPC_W-1:0] OP_SYSTEM   = 7'b1110011;
    // FENCE is part of the RV32I base set, so it must not be flagged illegal.
    localparam logic [OPC_W-1:0] OP_MISC_MEM = 7'b0001111;

    localparam logic [XLEN-1:0] INSTR_ECALL  = 32'h0000_0073;
    localparam logic [XLEN-1:0] INSTR_EBREAK = 32'h0010_0073;
    localparam logic [XLEN-1:0] INSTR_MRET   = 32'h3020_0073;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_type_t;

    typedef struct packed {
        logic [OPC_W-1:0] opcode;
        logic [REG_W-1:0] rd;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic [F3_W-1:0]  funct3;
        logic [F7_W-1:0]  funct7;
        logic [XLEN-1:0]  imm;
        logic             is_ecall;
        logic             is_ebreak;
        logic             is_mret;
        logic             is_csr;
        logic             illegal;
    } decoded_t;

endpackage

// File: rtl/decode_stage_imm_gen.sv
// Immediate generator: classifies the instruction format from its opcode and
// builds the sign-extended immediate. Purely combinational.
//   instr_i      raw 32-bit instruction
//   imm_type_c_o immediate format (IMM_NONE for R-type and unknown opcodes)
//   imm_c_o      sign-extended immediate, 0 when imm_type_c_o is IMM_NONE
module decode_stage_imm_gen
    import decode_stage_pkg::*;
(
    input  logic [XLEN-1:0] instr_i,
    output imm_type_t       imm_type_c_o,
    output logic [XLEN-1:0] imm_c_o
);

    // Format select by opcode; SYSTEM carries the CSR address in the I slot.
    always_comb begin
        imm_type_c_o = IMM_NONE;
        case (instr_i[6:0])
            OP_LUI, OP_AUIPC:                           imm_type_c_o = IMM_U;
            OP_JAL:                                     imm_type_c_o = IMM_J;
            OP_BRANCH:                                  imm_type_c_o = IMM_B;
            OP_STORE:                                   imm_type_c_o = IMM_S;
            OP_JALR, OP_LOAD, OP_IMM,
            OP_MISC_MEM, OP_SYSTEM:                     imm_type_c_o = IMM_I;
            default:                                    imm_type_c_o = IMM_NONE;
        endcase
    end

    // Immediate assembly per format.
    always_comb begin
        imm_c_o = '0;
        case (imm_type_c_o)
            IMM_I: imm_c_o = {{20{instr_i[31]}}, instr_i[31:20]};
            IMM_S: imm_c_o = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            IMM_B: imm_c_o = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                              instr_i[30:25], instr_i[11:8], 1'b0};
            IMM_U: imm_c_o = {instr_i[31:12], 12'b0};
            IMM_J: imm_c_o = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                              instr_i[20], instr_i[30:21], 1'b0};
            default: imm_c_o = '0;
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage between fetch and execute. Decodes the incoming
// instruction and stores the full record in a 2-entry skid buffer so execute
// back-pressure never drops an instruction already fetched.
//   clk, rstn             clock, async active-low reset
//   in_valid/in_ready     fetch handshake (in_ready registered: buffer not full)
//   pc, instr_raw         word-index pc and raw instruction from fetch
//   flush                 redirect from execute, discards every held entry
//   out_valid/out_ready   execute handshake for the head entry
//   out_pc..illegal       decoded fields of the head entry, read from registers
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int unsigned PC_W      = 32,
    parameter bit          DROP_ZERO = 1'b1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PC_W-1:0]  pc,
    input  logic [XLEN-1:0]  instr_raw,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PC_W-1:0]  out_pc,
    output logic [OPC_W-1:0] opcode,
    output logic [REG_W-1:0] rd,
    output logic [REG_W-1:0] rs1,
    output logic [REG_W-1:0] rs2,
    output logic [F3_W-1:0]  funct3,
    output logic [F7_W-1:0]  funct7,
    output logic [XLEN-1:0]  imm,
    output logic             is_ecall,
    output logic             is_ebreak,
    output logic             is_mret,
    output logic             is_csr,
    output logic             illegal
);

    localparam int unsigned DEPTH   = 2;
    localparam int unsigned CNT_W   = 2;

    imm_type_t       imm_type_c;
    logic [XLEN-1:0] imm_c;
    decoded_t        dec_c;

    decoded_t        mem_q    [DEPTH];
    logic [PC_W-1:0] pc_mem_q [DEPTH];
    logic [CNT_W-1:0] count_q, count_d;
    logic            rd_ptr_q, rd_ptr_d;
    logic            wr_ptr_q, wr_ptr_d;
    logic            out_valid_q, out_valid_d;
    logic            in_ready_q, in_ready_d;
    logic            push_c, pop_c;

    decode_stage_imm_gen u_imm_gen (
        .instr_i      (instr_raw),
        .imm_type_c_o (imm_type_c),
        .imm_c_o      (imm_c)
    );

    // Field split and SYSTEM classification, done before enqueue.
    always_comb begin
        logic sys_c;
        logic special_c;
        dec_c           = '0;
        dec_c.opcode    = instr_raw[6:0];
        dec_c.rd        = instr_raw[11:7];
        dec_c.funct3    = instr_raw[14:12];
        dec_c.rs1       = instr_raw[19:15];
        dec_c.rs2       = instr_raw[24:20];
        dec_c.funct7    = instr_raw[31:25];
        dec_c.imm       = imm_c;
        sys_c           = (instr_raw[6:0] == OP_SYSTEM);
        dec_c.is_ecall  = (instr_raw == INSTR_ECALL);
        dec_c.is_ebreak = (instr_raw == INSTR_EBREAK);
        dec_c.is_mret   = (instr_raw == INSTR_MRET);
        special_c       = dec_c.is_ecall | dec_c.is_ebreak | dec_c.is_mret;
        dec_c.is_csr    = sys_c && (instr_raw[14:12] != 3'd0);
        // Every base opcode except OP has an immediate format, so a missing
        // format on a non-OP opcode means the opcode is outside RV32I.
        dec_c.illegal   = ((imm_type_c == IMM_NONE) && (instr_raw[6:0] != OP_OP))
                        || (sys_c && (instr_raw[14:12] == 3'd0) && !special_c);
    end

    assign push_c = in_valid && in_ready_q && !flush
                 && !(DROP_ZERO && (instr_raw == '0));
    assign pop_c  = out_valid_q && out_ready && !flush;

    // Occupancy and pointer update; flush overrides push and pop.
    always_comb begin
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (flush) begin
            count_d  = '0;
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
        end else begin
            count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
            if (push_c) wr_ptr_d = ~wr_ptr_q;
            if (pop_c)  rd_ptr_d = ~rd_ptr_q;
        end
        out_valid_d = (count_d != '0);
        in_ready_d  = (count_d != CNT_W'(DEPTH));
    end

    // Control state.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count_q     <= '0;
            rd_ptr_q    <= 1'b0;
            wr_ptr_q    <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            count_q     <= count_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    // Entry storage; cleared on reset so idle outputs read as 0, not X.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i]    <= '0;
                pc_mem_q[i] <= '0;
            end
        end else if (push_c) begin
            mem_q[wr_ptr_q]    <= dec_c;
            pc_mem_q[wr_ptr_q] <= pc;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_pc    = pc_mem_q[rd_ptr_q];
    assign opcode    = mem_q[rd_ptr_q].opcode;
    assign rd        = mem_q[rd_ptr_q].rd;
    assign rs1       = mem_q[rd_ptr_q].rs1;
    assign rs2       = mem_q[rd_ptr_q].rs2;
    assign funct3    = mem_q[rd_ptr_q].funct3;
    assign funct7    = mem_q[rd_ptr_q].funct7;
    assign imm       = mem_q[rd_ptr_q].imm;
    assign is_ecall  = mem_q[rd_ptr_q].is_ecall;
    assign is_ebreak = mem_q[rd_ptr_q].is_ebreak;
    assign is_mret   = mem_q[rd_ptr_q].is_mret;
    assign is_csr    = mem_q[rd_ptr_q].is_csr;
    assign illegal   = mem_q[rd_ptr_q].illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed scenarios plus random traffic checked
// against a queue-based reference model with an arithmetic RV32I decoder.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rstn;
    logic        in_valid, in_ready, flush, out_valid, out_ready;
    logic [31:0] pc, instr_raw, out_pc, imm;
    logic [6:0]  opcode, funct7;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic        is_ecall, is_ebreak, is_mret, is_csr, illegal;

    // Second instance keeps all-zero instructions.
    logic        nz_in_valid, nz_in_ready, nz_out_valid;
    logic [31:0] nz_pc, nz_instr, nz_out_pc, nz_imm;
    logic [6:0]  nz_opcode, nz_funct7;
    logic [4:0]  nz_rd, nz_rs1, nz_rs2;
    logic [2:0]  nz_funct3;
    logic        nz_ecall, nz_ebreak, nz_mret, nz_csr, nz_illegal;

    always #5 clk = ~clk;

    decode_stage #(.PC_W(32), .DROP_ZERO(1'b1)) dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
        .pc(pc), .instr_raw(instr_raw), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3),
        .funct7(funct7), .imm(imm), .is_ecall(is_ecall), .is_ebreak(is_ebreak),
        .is_mret(is_mret), .is_csr(is_csr), .illegal(illegal)
    );

    decode_stage #(.PC_W(32), .DROP_ZERO(1'b0)) dut_nz (
        .clk(clk), .rstn(rstn), .in_valid(nz_in_valid), .in_ready(nz_in_ready),
        .pc(nz_pc), .instr_raw(nz_instr), .flush(1'b0),
        .out_valid(nz_out_valid), .out_ready(1'b1), .out_pc(nz_out_pc),
        .opcode(nz_opcode), .rd(nz_rd), .rs1(nz_rs1), .rs2(nz_rs2), .funct3(nz_funct3),
        .funct7(nz_funct7), .imm(nz_imm), .is_ecall(nz_ecall), .is_ebreak(nz_ebreak),
        .is_mret(nz_mret), .is_csr(nz_csr), .illegal(nz_illegal)
    );

    int errors = 0;
    int checks = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    typedef struct packed {
        logic [31:0] imm;
        logic        ecall, ebreak, mret, csr, ill;
    } exp_t;

    ent_t q[$];
    bit   m_ready;

    function automatic int sx(input int v, input int bits);
        if (v >= (1 << (bits - 1))) return v - (1 << bits);
        return v;
    endfunction

    // Reference decode, computed from the ISA rules with plain arithmetic.
    function automatic exp_t ref_decode(input logic [31:0] ins);
        exp_t e;
        int   v;
        logic [6:0] op;
        logic [2:0] f3;
        bit   known;
        op = ins[6:0];
        f3 = ins[14:12];
        e  = '0;
        known = 1'b1;
        case (op)
            7'h37, 7'h17: e.imm = 32'((longint'(ins[31:12]) * 4096) % 64'h1_0000_0000);
            7'h6f: begin
                v = int'({ins[31], ins[19:12], ins[20], ins[30:21]});
                e.imm = 32'(sx(v, 20) * 2);
            end
            7'h63: begin
                v = int'({ins[31], ins[7], ins[30:25], ins[11:8]});
                e.imm = 32'(sx(v, 12) * 2);
            end
            7'h23: begin
                v = int'({ins[31:25], ins[11:7]});
                e.imm = 32'(sx(v, 12));
            end
            7'h67, 7'h03, 7'h13, 7'h0f, 7'h73: begin
                v = int'(ins[31:20]);
                e.imm = 32'(sx(v, 12));
            end
            7'h33: e.imm = 32'd0;
            default: begin e.imm = 32'd0; known = 1'b0; end
        endcase
        e.ecall  = (ins == 32'h0000_0073);
        e.ebreak = (ins == 32'h0010_0073);
        e.mret   = (ins == 32'h3020_0073);
        e.csr    = (op == 7'h73) && (f3 != 3'd0);
        e.ill    = !known || ((op == 7'h73) && (f3 == 3'd0) && !e.ecall && !e.ebreak && !e.mret);
        return e;
    endfunction

    task automatic compare();
        exp_t e;
        check_eq("out_valid", 64'(out_valid), 64'(q.size() != 0));
        check_eq("in_ready", 64'(in_ready), 64'(m_ready));
        if (q.size() != 0) begin
            e = ref_decode(q[0].instr);
            check_eq("out_pc", 64'(out_pc), 64'(q[0].pc));
            check_eq("opcode", 64'(opcode), 64'(q[0].instr[6:0]));
            check_eq("rd", 64'(rd), 64'(q[0].instr[11:7]));
            check_eq("rs1", 64'(rs1), 64'(q[0].instr[19:15]));
            check_eq("rs2", 64'(rs2), 64'(q[0].instr[24:20]));
            check_eq("funct3", 64'(funct3), 64'(q[0].instr[14:12]));
            check_eq("funct7", 64'(funct7), 64'(q[0].instr[31:25]));
            check_eq("imm", 64'(imm), 64'(e.imm));
            check_eq("is_ecall", 64'(is_ecall), 64'(e.ecall));
            check_eq("is_ebreak", 64'(is_ebreak), 64'(e.ebreak));
            check_eq("is_mret", 64'(is_mret), 64'(e.mret));
            check_eq("is_csr", 64'(is_csr), 64'(e.csr));
            check_eq("illegal", 64'(illegal), 64'(e.ill));
        end
    endtask

    // One clock: predict the handshake, advance the model, then check after the edge.
    task automatic cycle();
        bit acc, pop;
        ent_t n;
        acc = in_valid && m_ready && !flush && (instr_raw != 32'd0);
        pop = (q.size() != 0) && out_ready;
        n.pc = pc;
        n.instr = instr_raw;
        @(posedge clk);
        if (flush) begin
            q.delete();
            m_ready = 1'b1;
        end else begin
            if (pop) void'(q.pop_front());
            if (acc) q.push_back(n);
            m_ready = (q.size() < 2);
        end
        #1;
        compare();
    endtask

    task automatic offer(input logic [31:0] p, input logic [31:0] ins);
        in_valid  = 1'b1;
        pc        = p;
        instr_raw = ins;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0] ops [11];
        logic [31:0] specials [4];
        logic [31:0] r;
        int k;
        ops = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h73, 7'h0f};
        specials = '{32'h0000_0073, 32'h0010_0073, 32'h3020_0073, 32'h3420_2773};
        r = $urandom;
        k = int'($urandom_range(0, 9));
        if (k == 0) return 32'd0;
        if (k == 1) return specials[$urandom_range(0, 3)];
        if (k == 2) return r;
        return {r[31:7], ops[$urandom_range(0, 10)]};
    endfunction

    initial begin
        rstn = 1'b1; in_valid = 1'b0; pc = '0; instr_raw = '0; flush = 1'b0; out_ready = 1'b1;
        nz_in_valid = 1'b0; nz_pc = '0; nz_instr = '0;
        q.delete();
        m_ready = 1'b1;
        #2 rstn = 1'b0;
        #2;
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_in_ready", 64'(in_ready), 64'd1);
        check_eq("rst_imm", 64'(imm), 64'd0);
        check_eq("rst_opcode", 64'(opcode), 64'd0);
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;

        // addi sp,sp,-32
        offer(32'd1, 32'hfe01_0113);
        cycle();
        in_valid = 1'b0;
        check_eq("addi_opcode", 64'(opcode), 64'h13);
        check_eq("addi_rd", 64'(rd), 64'd2);
        check_eq("addi_rs1", 64'(rs1), 64'd2);
        check_eq("addi_imm", 64'(imm), 64'hffff_ffe0);
        check_eq("addi_illegal", 64'(illegal), 64'd0);
        cycle();

        // jal forward and backward
        offer(32'd2, 32'h08c0_00ef);
        cycle();
        check_eq("jal_rd", 64'(rd), 64'd1);
        check_eq("jal_imm", 64'(imm), 64'h8c);
        offer(32'd3, 32'hfc9f_f0ef);
        cycle();
        in_valid = 1'b0;
        check_eq("jal_neg_imm", 64'(imm), 64'hffff_ffc8);
        cycle();

        // ecall, ebreak, mret back to back, then csrrs
        offer(32'd10, 32'h0000_0073);
        cycle();
        check_eq("seq_ecall", 64'({is_ecall, is_ebreak, is_mret}), 64'b100);
        offer(32'd11, 32'h0010_0073);
        cycle();
        check_eq("seq_ebreak", 64'({is_ecall, is_ebreak, is_mret}), 64'b010);
        offer(32'd12, 32'h3020_0073);
        cycle();
        check_eq("seq_mret", 64'({is_ecall, is_ebreak, is_mret}), 64'b001);
        offer(32'd13, 32'h3420_2773);
        cycle();
        in_valid = 1'b0;
        check_eq("csrrs_is_csr", 64'(is_csr), 64'd1);
        check_eq("csrrs_flags", 64'({is_ecall, is_ebreak, is_mret, illegal}), 64'd0);
        cycle();

        // back-pressure: 5 and 6 taken, 7 held, then drained in order
        out_ready = 1'b0;
        offer(32'd5, 32'h0010_0093);
        cycle();
        offer(32'd6, 32'h0020_0113);
        cycle();
        check_eq("bp_full_ready", 64'(in_ready), 64'd0);
        offer(32'd7, 32'h0030_0193);
        cycle();
        check_eq("bp_head5", 64'(out_pc), 64'd5);
        out_ready = 1'b1;
        cycle();
        check_eq("bp_head6", 64'(out_pc), 64'd6);
        cycle();
        in_valid = 1'b0;
        check_eq("bp_head7", 64'(out_pc), 64'd7);
        cycle();
        check_eq("bp_drained", 64'(out_valid), 64'd0);

        // flush while full, with a push and pop offered
        out_ready = 1'b0;
        offer(32'd20, 32'h0000_0013);
        cycle();
        offer(32'd21, 32'h0000_0013);
        cycle();
        offer(32'd22, 32'h0000_0013);
        out_ready = 1'b1;
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        in_valid = 1'b0;
        check_eq("flush_valid", 64'(out_valid), 64'd0);
        check_eq("flush_ready", 64'(in_ready), 64'd1);
        cycle();

        // zero instruction: dropped here, kept as illegal by the DROP_ZERO=0 copy
        offer(32'd30, 32'd0);
        nz_in_valid = 1'b1;
        nz_pc = 32'd30;
        nz_instr = 32'd0;
        cycle();
        in_valid = 1'b0;
        nz_in_valid = 1'b0;
        check_eq("zero_dropped", 64'(out_valid), 64'd0);
        check_eq("nz_valid", 64'(nz_out_valid), 64'd1);
        check_eq("nz_illegal", 64'(nz_illegal), 64'd1);
        check_eq("nz_pc", 64'(nz_out_pc), 64'd30);
        cycle();
        check_eq("nz_popped", 64'(nz_out_valid), 64'd0);

        // asynchronous reset with one entry held
        out_ready = 1'b0;
        offer(32'd40, 32'hfe01_0113);
        cycle();
        in_valid = 1'b0;
        #3 rstn = 1'b0;
        #1;
        check_eq("arst_valid", 64'(out_valid), 64'd0);
        check_eq("arst_ready", 64'(in_ready), 64'd1);
        q.delete();
        m_ready = 1'b1;
        #2 rstn = 1'b1;
        out_ready = 1'b1;
        cycle();

        // random traffic
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            pc        = $urandom;
            instr_raw = rand_instr();
            cycle();
        end
        in_valid = 1'b0;
        flush = 1'b0;
        out_ready = 1'b1;
        repeat (3) cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
